// File: rtl/msu_job_sched.sv
// Round-robin scheduler sharing one modular squarer among NUM_REQ job sources; one job in flight.
// Latency: trivial or bad jobs respond 1 cycle after grant, others after lock + start + iterations + 1; the result is held until rsp_ready.
module msu_job_sched #(
  parameter int NUM_REQ  = 4,
  parameter int T_LEN    = 64,
  parameter int WRD_BITS = 16,
  parameter int NUM_WRDS = 5,
  parameter int DAT_BITS = 64,
  parameter int TOT_BITS = NUM_WRDS * (WRD_BITS + 1),
  parameter int LOCK_TO  = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*T_LEN-1:0]      req_t_start,
  input  logic [NUM_REQ*T_LEN-1:0]      req_t_final,
  input  logic [NUM_REQ*DAT_BITS-1:0]   req_sq_in,
  output logic                          sq_reset,
  output logic                          sq_start,
  output logic [DAT_BITS-1:0]           sq_in,
  input  logic                          sq_valid,
  input  logic [TOT_BITS-1:0]           sq_out,
  input  logic                          sq_locked,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [T_LEN-1:0]              rsp_t,
  output logic [TOT_BITS-1:0]           rsp_sq_out,
  output logic                          rsp_err
);

  localparam int ID_W     = $clog2(NUM_REQ);
  localparam int TMR_W    = $clog2(LOCK_TO + 1);
  localparam int PAD_BITS = NUM_WRDS * WRD_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_LOCK, S_START, S_COMPUTE, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [T_LEN-1:0]    t_cur_q, t_cur_d;
  logic [T_LEN-1:0]    t_fin_q, t_fin_d;
  logic [DAT_BITS-1:0] sq_in_q, sq_in_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [T_LEN-1:0]    rsp_t_q, rsp_t_d;
  logic [TOT_BITS-1:0] rsp_sq_out_q, rsp_sq_out_d;
  logic                rsp_err_q, rsp_err_d;

  logic                win_vld;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     scan_id;
  logic [T_LEN-1:0]    win_t_start;
  logic [T_LEN-1:0]    win_t_final;
  logic [DAT_BITS-1:0] win_sq_in;

  // Each data word lands in the low WRD_BITS of its slot; the redundant carry bit stays 0.
  function automatic logic [TOT_BITS-1:0] expand_redun(input logic [DAT_BITS-1:0] d);
    logic [PAD_BITS-1:0] pad;
    logic [TOT_BITS-1:0] r;
    pad = PAD_BITS'(d);
    r   = '0;
    for (int k = 0; k < NUM_WRDS; k++) begin
      r[k*(WRD_BITS+1) +: WRD_BITS] = pad[k*WRD_BITS +: WRD_BITS];
    end
    return r;
  endfunction

  // Scan from the far end back to rr_ptr so the last hit is the first requester in rotation order.
  always_comb begin
    win_vld     = 1'b0;
    win_id      = '0;
    scan_id     = '0;
    win_t_start = '0;
    win_t_final = '0;
    win_sq_in   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      scan_id = ID_W'((int'(rr_ptr_q) + j) % NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (scan_id == ID_W'(i))) begin
          win_vld = 1'b1;
          win_id  = scan_id;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_t_start = req_t_start[i*T_LEN +: T_LEN];
        win_t_final = req_t_final[i*T_LEN +: T_LEN];
        win_sq_in   = req_sq_in[i*DAT_BITS +: DAT_BITS];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    t_cur_d      = t_cur_q;
    t_fin_d      = t_fin_q;
    sq_in_d      = sq_in_q;
    timer_d      = timer_q;
    rsp_id_d     = rsp_id_q;
    rsp_t_d      = rsp_t_q;
    rsp_sq_out_d = rsp_sq_out_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (!win_vld) begin
          state_d = S_IDLE;
        end else begin
          rr_ptr_d     = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
          t_cur_d      = win_t_start;
          t_fin_d      = win_t_final;
          sq_in_d      = win_sq_in;
          timer_d      = '0;
          rsp_id_d     = win_id;
          rsp_t_d      = win_t_start;
          rsp_sq_out_d = '0;
          rsp_err_d    = 1'b0;
          if (win_t_start == win_t_final) begin
            state_d      = S_RESP;
            rsp_sq_out_d = expand_redun(win_sq_in);
          end else if (win_t_start > win_t_final) begin
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        if (sq_locked) begin
          state_d = S_START;
        end else if (timer_q == TMR_W'(LOCK_TO - 1)) begin
          state_d      = S_RESP;
          rsp_err_d    = 1'b1;
          rsp_t_d      = t_cur_q;
          rsp_sq_out_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_START: begin
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (sq_valid) begin
          t_cur_d = t_cur_q + T_LEN'(1);
          if (t_cur_q == t_fin_q - T_LEN'(1)) begin
            state_d      = S_RESP;
            rsp_sq_out_d = sq_out;
            rsp_t_d      = t_fin_q;
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      t_cur_q      <= '0;
      t_fin_q      <= '0;
      sq_in_q      <= '0;
      timer_q      <= '0;
      rsp_id_q     <= '0;
      rsp_t_q      <= '0;
      rsp_sq_out_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      t_cur_q      <= t_cur_d;
      t_fin_q      <= t_fin_d;
      sq_in_q      <= sq_in_d;
      timer_q      <= timer_d;
      rsp_id_q     <= rsp_id_d;
      rsp_t_q      <= rsp_t_d;
      rsp_sq_out_q <= rsp_sq_out_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // The squarer leaves reset only once a job is committed, and stays out until the result is taken.
  assign req_ready  = (state_q == S_GRANT && win_vld) ? (NUM_REQ'(1) << win_id) : '0;
  assign sq_reset   = (state_q == S_IDLE) || (state_q == S_GRANT);
  assign sq_start   = (state_q == S_START);
  assign sq_in      = sq_in_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_t      = rsp_t_q;
  assign rsp_sq_out = rsp_sq_out_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_msu_job_sched.sv
// Directed bench for msu_job_sched with a behavioural squarer and an expected-response queue.
module tb_msu_job_sched;

  localparam int NUM_REQ  = 4;
  localparam int T_LEN    = 64;
  localparam int WRD_BITS = 16;
  localparam int NUM_WRDS = 5;
  localparam int DAT_BITS = 64;
  localparam int TOT_BITS = NUM_WRDS * (WRD_BITS + 1);
  localparam int LOCK_TO  = 16;
  localparam int ID_W     = 2;
  localparam int SQ_PER   = 5;

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [T_LEN-1:0]    t;
    logic [TOT_BITS-1:0] sq;
    logic                err;
  } exp_t;

  logic                        clk;
  logic                        reset_n;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*T_LEN-1:0]    req_t_start;
  logic [NUM_REQ*T_LEN-1:0]    req_t_final;
  logic [NUM_REQ*DAT_BITS-1:0] req_sq_in;
  logic                        sq_reset;
  logic                        sq_start;
  logic [DAT_BITS-1:0]         sq_in;
  logic                        sq_valid;
  logic [TOT_BITS-1:0]         sq_out;
  logic                        sq_locked;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  logic [T_LEN-1:0]            rsp_t;
  logic [TOT_BITS-1:0]         rsp_sq_out;
  logic                        rsp_err;

  int   n_tests;
  int   n_fail;
  int   n_start;
  int   pulses;
  int   pulses_at_rsp;
  int   starts0;
  int   cycles;
  logic lock_en;
  exp_t exp_q[$];

  msu_job_sched #(
    .NUM_REQ(NUM_REQ), .T_LEN(T_LEN), .WRD_BITS(WRD_BITS), .NUM_WRDS(NUM_WRDS),
    .DAT_BITS(DAT_BITS), .TOT_BITS(TOT_BITS), .LOCK_TO(LOCK_TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_t_start(req_t_start), .req_t_final(req_t_final), .req_sq_in(req_sq_in),
    .sq_reset(sq_reset), .sq_start(sq_start), .sq_in(sq_in),
    .sq_valid(sq_valid), .sq_out(sq_out), .sq_locked(sq_locked),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_t(rsp_t), .rsp_sq_out(rsp_sq_out), .rsp_err(rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Squarer result after n iterations.
  function automatic logic [TOT_BITS-1:0] sq_f(input int n);
    return {21'h1ABCD ^ 21'(n), 32'hDEAD_0000 | 32'(n), 32'(n * 7 + 3)};
  endfunction

  function automatic logic [TOT_BITS-1:0] exp_expand(input logic [DAT_BITS-1:0] d);
    logic [TOT_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < DAT_BITS; i++) r[(i / WRD_BITS) * (WRD_BITS + 1) + (i % WRD_BITS)] = d[i];
    return r;
  endfunction

  // Behavioural squarer: one sq_valid every SQ_PER cycles after sq_start, cleared by sq_reset.
  initial begin
    logic running;
    int   cnt;
    running   = 1'b0;
    cnt       = 0;
    pulses    = 0;
    sq_valid  = 1'b0;
    sq_out    = '0;
    sq_locked = 1'b0;
    forever begin
      @(negedge clk);
      sq_locked = lock_en;
      sq_valid  = 1'b0;
      if (sq_reset === 1'b1) begin
        running = 1'b0;
        cnt     = 0;
        pulses  = 0;
      end else if (sq_start === 1'b1) begin
        running = 1'b1;
        cnt     = 0;
        pulses  = 0;
      end else if (running) begin
        cnt++;
        if (cnt == SQ_PER) begin
          cnt      = 0;
          pulses++;
          sq_valid = 1'b1;
          sq_out   = sq_f(pulses);
        end
      end
    end
  end

  initial begin
    n_start = 0;
    forever begin
      @(negedge clk);
      if (sq_start === 1'b1) n_start++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [T_LEN-1:0] t, input logic [TOT_BITS-1:0] sq,
                          input logic err);
    exp_t e;
    e.id  = ID_W'(id);
    e.t   = t;
    e.sq  = sq;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input int id, input logic [T_LEN-1:0] ts, input logic [T_LEN-1:0] tf,
                           input logic [DAT_BITS-1:0] d);
    req_t_start[id*T_LEN +: T_LEN]     = ts;
    req_t_final[id*T_LEN +: T_LEN]     = tf;
    req_sq_in[id*DAT_BITS +: DAT_BITS] = d;
    req_valid[id]                      = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input int id);
    int cyc;
    cyc = 0;
    while (req_ready[id] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_gnt"}, req_ready, NUM_REQ'(1) << id);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic submit(input string tag, input int id, input logic [T_LEN-1:0] ts,
                        input logic [T_LEN-1:0] tf, input logic [DAT_BITS-1:0] d);
    drive_req(id, ts, tf, d);
    wait_grant(tag, id);
  endtask

  task automatic wait_rsp(input string tag, input int hold);
    exp_t e;
    int   cyc;
    logic stable;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    pulses_at_rsp = pulses;
    chk({tag, "_vld"}, rsp_valid, 1'b1);
    chk({tag, "_sb"}, exp_q.size() > 0, 1'b1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    if (rsp_valid !== 1'b1) return;
    stable = 1'b1;
    repeat (hold) begin
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_t !== e.t || rsp_sq_out !== e.sq ||
          rsp_err !== e.err || req_ready !== '0)
        stable = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) chk({tag, "_stable"}, stable, 1'b1);
    chk({tag, "_id"}, rsp_id, e.id);
    chk({tag, "_t"}, rsp_t, e.t);
    chk({tag, "_sq"}, rsp_sq_out, e.sq);
    chk({tag, "_err"}, rsp_err, e.err);
    chk({tag, "_rdy0"}, req_ready, '0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_sqrst"}, sq_reset, 1'b1);
    chk({tag, "_done"}, rsp_valid, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    req_valid   = '0;
    req_t_start = '0;
    req_t_final = '0;
    req_sq_in   = '0;
    rsp_ready   = 1'b0;
    lock_en     = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", req_ready, '0);
    chk("rst_sq_start", sq_start, 1'b0);
    chk("rst_sq_reset", sq_reset, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_id", rsp_id, '0);
    chk("rst_rsp_t", rsp_t, '0);
    chk("rst_rsp_sq", rsp_sq_out, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single job on requester 2, three iterations.
    starts0 = n_start;
    push_exp(2, 3, sq_f(3), 1'b0);
    submit("t1", 2, 0, 3, 64'h0123_4567_89AB_CDEF);
    chk("t1_sq_in", sq_in, 64'h0123_4567_89AB_CDEF);
    wait_rsp("t1", 0);
    chk("t1_starts", n_start - starts0, 1);
    chk("t1_pulses", pulses_at_rsp, 3);

    // All requesters held valid from a fresh pointer: grants 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_t_start[i*T_LEN +: T_LEN]     = '0;
      req_t_final[i*T_LEN +: T_LEN]     = 64'd1;
      req_sq_in[i*DAT_BITS +: DAT_BITS] = DAT_BITS'(i);
    end
    for (int k = 0; k < 5; k++) push_exp(k % NUM_REQ, 1, sq_f(1), 1'b0);
    req_valid = '1;
    for (int k = 0; k < 5; k++) wait_rsp("t2", 0);
    req_valid = '0;

    // Zero-iteration and reversed-count jobs never start the squarer.
    starts0 = n_start;
    push_exp(1, 7, exp_expand(64'd1), 1'b0);
    submit("t3_zero", 1, 7, 7, 64'd1);
    wait_rsp("t3_zero", 0);
    push_exp(3, 5, exp_expand(64'hFFFF_0000_8000_0001), 1'b0);
    submit("t3_wide", 3, 5, 5, 64'hFFFF_0000_8000_0001);
    wait_rsp("t3_wide", 0);
    push_exp(2, 20, '0, 1'b1);
    submit("t3_neg", 2, 20, 4, 64'h55);
    wait_rsp("t3_neg", 0);
    chk("t3_no_start", n_start - starts0, 0);

    // Lock never arrives: abort after LOCK_TO cycles in LOCK.
    lock_en = 1'b0;
    starts0 = n_start;
    push_exp(0, 5, '0, 1'b1);
    submit("t4", 0, 5, 9, 64'hABCD);
    chk("t4_sq_reset_lock", sq_reset, 1'b0);
    cycles = 0;
    while (rsp_valid !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    chk("t4_latency", cycles, LOCK_TO);
    wait_rsp("t4", 0);
    chk("t4_no_start", n_start - starts0, 0);
    lock_en = 1'b1;

    // Response held 20 cycles while another requester waits.
    push_exp(0, 12, sq_f(2), 1'b0);
    submit("t5_a", 0, 10, 12, 64'h1111_2222_3333_4444);
    push_exp(1, 3, exp_expand(64'h9876_5432_10FE_DCBA), 1'b0);
    drive_req(1, 3, 3, 64'h9876_5432_10FE_DCBA);
    wait_rsp("t5_hold", 20);
    wait_grant("t5_b", 1);
    wait_rsp("t5_b", 0);

    // Reset mid-computation drops the job and clears the round-robin pointer.
    submit("t6", 2, 0, 10, 64'h77);
    cycles = 0;
    while (pulses < 5 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid", rsp_valid, 1'b0);
    chk("t6_sq_reset", sq_reset, 1'b1);
    chk("t6_req_ready", req_ready, '0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_no_rsp", rsp_valid, 1'b0);
    push_exp(0, 1, exp_expand(64'hA0), 1'b0);
    push_exp(3, 1, exp_expand(64'hA3), 1'b0);
    drive_req(0, 1, 1, 64'hA0);
    drive_req(3, 1, 1, 64'hA3);
    wait_grant("t6_rr", 0);
    wait_rsp("t6_a", 0);
    wait_grant("t6_b", 3);
    wait_rsp("t6_b", 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
